// File: rtl/frame_sequencer.sv
// frame_sequencer: streams a stored vector frame from the point buffer into the line drawer, with blank dwell and stall watchdog.
module frame_sequencer #(
  parameter int ADDR_W       = 11,
  parameter int DWELL_CYCLES = 16,
  parameter int WDT_CYCLES   = 1048576,
  parameter int SHIFT        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_valid,
  input  logic [ADDR_W-1:0] num_points,
  output logic [ADDR_W-1:0] read_address,
  input  logic [24:0]       point,
  output logic              done_drawing,
  input  logic              ready,
  output logic              draw,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic [3:0]        shift,
  output logic              beam,
  output logic              busy,
  output logic              fault
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DWELL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;
  localparam int WW  = $clog2(WDT_CYCLES + 1);
  localparam int DWW = $clog2(DWELL_CYCLES + 2);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx, r_np, r_read_address;
  logic              r_pbeam, r_draw, r_beam, r_done, r_fault;
  logic [10:0]       r_px, r_py;
  logic [11:0]       r_x, r_y;
  logic [WW-1:0]     r_wdt;
  logic [DWW-1:0]    r_dw;
  logic [ADDR_W-1:0] w_next;
  logic              w_unused;

  assign w_next       = r_idx + 1'b1;
  assign w_unused     = ^{point[12], point[0]};
  assign read_address = r_read_address;
  assign done_drawing = r_done;
  assign draw         = r_draw;
  assign x            = r_x;
  assign y            = r_y;
  assign shift        = 4'(SHIFT);
  assign beam         = r_beam;
  assign busy         = r_state != S_IDLE && r_state != S_FAULT;
  assign fault        = r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_np           <= '0;
      r_read_address <= '0;
      r_pbeam        <= 1'b0;
      r_px           <= '0;
      r_py           <= '0;
      r_draw         <= 1'b0;
      r_beam         <= 1'b0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_wdt          <= '0;
      r_dw           <= '0;
    end else begin
      r_draw <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_beam         <= 1'b0;
          r_idx          <= '0;
          r_read_address <= '0;
          r_np           <= num_points;
          if (enable && frame_valid) r_state <= (num_points == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH: r_state <= S_DATA;
        S_DATA: begin
          r_pbeam <= point[24];
          r_px    <= point[23:13];
          r_py    <= point[11:1];
          r_wdt   <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!enable) begin
            r_beam         <= 1'b0;
            r_idx          <= '0;
            r_read_address <= '0;
            r_state        <= S_IDLE;
          end else if (ready) begin
            r_draw         <= 1'b1;
            r_x            <= {1'b0, r_px};
            r_y            <= {1'b0, r_py};
            r_beam         <= r_pbeam;
            r_idx          <= w_next;
            r_read_address <= w_next;
            r_dw           <= '0;
            r_state        <= (!r_pbeam && DWELL_CYCLES > 0) ? S_DWELL : (w_next == r_np) ? S_DONE : S_FETCH;
          end else if (r_wdt == WW'(WDT_CYCLES - 1)) begin
            r_beam  <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_wdt <= r_wdt + 1'b1;
          end
        end
        S_DWELL: begin
          if (r_dw == DWW'(DWELL_CYCLES - 1)) r_state <= (r_idx == r_np) ? S_DONE : S_FETCH;
          else r_dw <= r_dw + 1'b1;
        end
        S_DONE: begin
          r_done         <= 1'b1;
          r_beam         <= 1'b0;
          r_idx          <= '0;
          r_read_address <= '0;
          r_state        <= S_IDLE;
        end
        S_FAULT: begin
          r_beam  <= 1'b0;
          r_fault <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench with a timing model of the frame sequencer and a drawer model.
module tb_frame_sequencer;
  localparam int DW = 16;
  localparam int WDT = 64;
  localparam int SH = 3;

  typedef struct {
    bit is_done;
    int t;
    int x;
    int y;
    int b;
  } exp_t;

  logic        clk = 0;
  logic        reset, enable, frame_valid, ready;
  logic [10:0] num_points, read_address;
  logic [24:0] point;
  logic        done_drawing, draw, beam, busy, fault;
  logic [11:0] x, y;
  logic [3:0]  shift;

  logic [24:0] mem [0:2047];
  exp_t        q[$];
  int          cyc = 0;
  int          mode = 0;
  int          checks = 0;
  int          errors = 0;

  frame_sequencer #(.ADDR_W(11), .DWELL_CYCLES(DW), .WDT_CYCLES(WDT), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
    .num_points(num_points), .read_address(read_address), .point(point),
    .done_drawing(done_drawing), .ready(ready), .draw(draw), .x(x), .y(y),
    .shift(shift), .beam(beam), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    point <= mem[read_address];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Drawer: mode 0 always idle, mode 1 random busy time after each draw, mode 2 stalls forever after a draw
  initial begin
    int bsy;
    bsy = 0;
    ready = 1;
    forever begin
      @(negedge clk);
      if (mode == 0) ready = 1;
      else if (mode == 1) begin
        if (draw) bsy = $urandom_range(0, 10);
        else if (bsy > 0) bsy--;
        ready = (bsy == 0);
      end else if (draw) ready = 0;
    end
  end

  // Monitor: every draw or done pulse must match the head of the expectation queue
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (draw) begin
      if (q.size() == 0) fail("unexpected_draw");
      else begin
        e = q.pop_front();
        chk("draw_kind", 0, int'(e.is_done));
        if (e.t >= 0) chk("draw_time", cyc, e.t);
        chk("draw_x", int'(x), e.x);
        chk("draw_y", int'(y), e.y);
        chk("draw_beam", int'(beam), e.b);
        chk("draw_busy", int'(busy), 1);
      end
    end
    if (done_drawing) begin
      if (q.size() == 0) fail("unexpected_done");
      else begin
        e = q.pop_front();
        chk("done_kind", 1, int'(e.is_done));
        if (e.t >= 0) chk("done_time", cyc, e.t);
        chk("done_beam", int'(beam), 0);
      end
    end
  end

  // Reference timing: first draw 4 cycles after start, 3 cycles per point, plus DW after a blanked one
  task automatic push_frame(input int c, input int n, input bit timed, output int d);
    int t;
    exp_t e;
    logic [24:0] p;
    t = c + 4;
    d = c + 2;
    for (int k = 0; k < n; k++) begin
      p = mem[k];
      e.is_done = 0;
      e.t = timed ? t : -1;
      e.x = int'(p[23:13]);
      e.y = int'(p[11:1]);
      e.b = int'(p[24]);
      q.push_back(e);
      t += 3 + (p[24] ? 0 : DW);
      d = t - 2;
    end
    e.is_done = 1;
    e.t = timed ? d : -1;
    e.x = 0;
    e.y = 0;
    e.b = 0;
    q.push_back(e);
  endtask

  task automatic push_first_draw(input int c);
    exp_t e;
    logic [24:0] p;
    p = mem[0];
    e.is_done = 0;
    e.t = c + 4;
    e.x = int'(p[23:13]);
    e.y = int'(p[11:1]);
    e.b = int'(p[24]);
    q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done_drawing;
    end
    if (!seen) fail("done_timeout");
  endtask

  task automatic frame(input int n, input bit timed, input int reps);
    int c, d;
    num_points = 11'(n);
    enable = 1;
    frame_valid = 1;
    c = cyc;
    for (int r = 0; r < reps; r++) begin
      push_frame(c, n, timed, d);
      c = d;
    end
    if (reps == 1) begin
      @(negedge clk);
      num_points = 11'($urandom);
    end
    for (int r = 0; r < reps; r++) wait_done();
    frame_valid = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_draw", int'(draw), 0);
    chk("rst_beam", int'(beam), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_shift", int'(shift), SH);
    chk("rst_addr", int'(read_address), 0);
    chk("rst_done", int'(done_drawing), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int c, d, n;
    for (int k = 0; k < 2048; k++) mem[k] = '0;
    reset = 1;
    enable = 0;
    frame_valid = 0;
    num_points = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 0;
    @(negedge clk);

    mem[0] = {1'b1, 11'd100, 1'b0, 11'd5, 1'b0};
    mem[1] = {1'b1, 11'd200, 1'b0, 11'd6, 1'b0};
    mem[2] = {1'b1, 11'd300, 1'b0, 11'd7, 1'b0};
    frame(3, 1, 2);
    @(negedge clk);

    mem[0] = {1'b0, 11'd10, 1'b1, 11'd20, 1'b1};
    mem[1] = {1'b1, 11'd2047, 1'b0, 11'd2047, 1'b0};
    frame(2, 1, 1);
    @(negedge clk);

    frame(0, 1, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) mem[k] = 25'($urandom);
      frame(n, 1, 1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    mode = 1;
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) mem[k] = 25'($urandom);
      frame(n, 0, 1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    mode = 0;
    repeat (2) @(negedge clk);

    // enable dropped while stalled in ISSUE, then a clean restart from address 0
    for (int k = 0; k < 3; k++) mem[k] = 25'($urandom) | 25'h1000000;
    mode = 2;
    num_points = 3;
    enable = 1;
    frame_valid = 1;
    c = cyc;
    push_first_draw(c);
    while (cyc < c + 14) @(negedge clk);
    enable = 0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_beam", int'(beam), 0);
    chk("abort_addr", int'(read_address), 0);
    repeat (5) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    mode = 0;
    @(negedge clk);
    enable = 1;
    c = cyc;
    push_frame(c, 3, 1, d);
    wait_done();
    frame_valid = 0;
    repeat (2) @(negedge clk);

    // watchdog: drawer stalls after the first draw
    mode = 2;
    frame_valid = 1;
    c = cyc;
    push_first_draw(c);
    while (cyc < c + 69) @(negedge clk);
    chk("wdt_not_yet", int'(fault), 0);
    @(negedge clk);
    chk("wdt_fault", int'(fault), 1);
    chk("wdt_beam", int'(beam), 0);
    chk("wdt_busy", int'(busy), 0);
    mode = 0;
    repeat (20) @(negedge clk);
    chk("wdt_sticky", int'(fault), 1);
    frame_valid = 0;
    enable = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_reset_outputs();
    @(negedge clk);

    // reset with a draw pending, then a fresh frame from point 0
    for (int k = 0; k < 4; k++) mem[k] = 25'($urandom) | 25'h1000000;
    num_points = 4;
    enable = 1;
    frame_valid = 1;
    c = cyc;
    push_first_draw(c);
    while (cyc < c + 6) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs();
    reset = 0;
    c = cyc;
    push_frame(c, 4, 1, d);
    wait_done();
    frame_valid = 0;
    repeat (5) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Sequences a stored vector frame from the UART point buffer into the line-draw controller. Fetches points in order, issues one draw command per point with the correct beam state, and spaces blanked moves with a settle dwell. Signals end-of-frame back to the buffer and repeats the frame while one is available. A watchdog latches a fault and forces the beam off if the drawer stalls.

## Interface
Parameters:
- ADDR_W, 11, point-buffer address and point-count width
- DWELL_CYCLES, 16, minimum cycles after a blanked (beam-off) draw before the next point may issue; 0 disables the dwell
- WDT_CYCLES, 1048576, consecutive cycles of `ready` low in ISSUE that trigger a fault
- SHIFT, 0, constant value driven on `shift`

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  allows frames to start; low aborts at the next issue point
- frame_valid  in  1  buffer holds a complete frame (level)
- num_points  in  ADDR_W  number of points in the frame
- read_address  out  ADDR_W  buffer read address (registered)
- point  in  25  buffer read data, valid 1 cycle after `read_address`; [24]=beam on, [23:13]=x, [11:1]=y
- done_drawing  out  1  one-cycle pulse at end of each completed frame
- ready  in  1  line drawer idle and able to accept a command
- draw  out  1  one-cycle command strobe to the drawer
- x, y  out  12 each  target coordinate, zero-extended from 11 bits
- shift  out  4  drawer step shift, constant SHIFT
- beam  out  1  beam enable
- busy  out  1  high in any state except IDLE and FAULT
- fault  out  1  sticky watchdog fault

## Operation
- States: IDLE, FETCH, DATA, ISSUE, DWELL, DONE, FAULT.
- IDLE: beam=0, idx=0, read_address=0.
  - If enable && frame_valid && num_points!=0: go to FETCH.
  - If enable && frame_valid && num_points==0: go to DONE.
- FETCH: wait one cycle for RAM latency, then go to DATA.
- DATA: latch `point` into the internal point register, clear the watchdog, then go to ISSUE.
- ISSUE:
  - If !enable: beam<=0, idx<=0, read_address<=0, go to IDLE. No done_drawing pulse.
  - Else if ready:
    - Drive draw<=1 for one cycle, x<={1'b0,pt[23:13]}, y<={1'b0,pt[11:1]}, beam<=pt[24].
    - idx<=idx+1, read_address<=idx+1.
    - Next state: if pt[24]==0 and DWELL_CYCLES>0, go to DWELL. Else if idx+1==num_points, go to DONE. Else go to FETCH.
  - Else: increment the watchdog. If it reaches WDT_CYCLES-1, go to FAULT.
- DWELL: count DWELL_CYCLES cycles, then go to DONE if idx==num_points, else FETCH.
- DONE: done_drawing<=1 for one cycle, beam<=0, idx<=0, read_address<=0, then go to IDLE. IDLE restarts the frame on the next cycle if frame_valid is still high.
- FAULT: beam=0, draw=0, fault=1. Exits only on reset.
- num_points is sampled on entry from IDLE and held for the whole frame. Changes mid-frame are ignored.
- beam holds its last value between draws within a frame. It is 0 in IDLE, DONE and FAULT.

## Timing
- Reset values: draw=0, beam=0, x=0, y=0, shift=SHIFT, read_address=0, done_drawing=0, busy=0, fault=0; state=IDLE.
- Reset asserted in any state returns the block to IDLE within one edge. No draw or done_drawing pulse is emitted on that edge.
- Start latency: IDLE to first draw is 4 cycles when ready is already high (IDLE→FETCH→DATA→ISSUE→draw).
- Steady-state throughput with ready held high and all points beam-on: one draw every 3 cycles.
- A blanked point adds DWELL_CYCLES cycles before the next FETCH.
- Handshake: `ready` is sampled only in ISSUE, 3 or more cycles after the previous draw. The drawer must drop ready within 2 cycles of `draw`.
- Last point: DONE follows draw (or dwell), so done_drawing pulses 1 cycle after the final draw, or 1 cycle after the dwell ends.
- idx and read_address never exceed num_points. No wrap-around occurs.

## Test plan
- Frame of 3 beam-on points (x=100,200,300; y=5,6,7), ready high, DWELL_CYCLES=0 → draw pulses at cycles 4, 7, 10 after start with matching x/y and beam=1; done_drawing at cycle 11; the frame restarts while frame_valid stays high.
- Point with [24]=0 followed by one with [24]=1, DWELL_CYCLES=16 → first draw has beam=0; the second draw comes 19 cycles after the first, with beam=1.
- num_points=0 with frame_valid=1 → no draw; done_drawing pulses 2 cycles after frame_valid is seen; beam stays 0.
- ready held low after the first draw, WDT_CYCLES=64 → fault=1 and beam=0 after 64 ISSUE cycles; no further draws until reset.
- enable dropped while waiting in ISSUE mid-frame → no draw, beam=0, no done_drawing, busy=0; raising enable again restarts at address 0.
- Reset asserted mid-frame with draw pending → all outputs at reset values next cycle; a fresh frame draws from point 0.
